// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: a shared prescaler produces a base tick,
// and each channel runs its own OFF/ON/BLINK/ONESHOT/FOLLOW pattern counted in ticks.
module led_pattern_gen #(
    parameter int NCH      = 4,
    parameter int TICK_DIV = 100000,
    parameter int CNT_W    = 16,
    localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [2:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_duty,
    input  logic             sync_clr,
    input  logic [NCH-1:0]   src_in,
    output logic             tick_o,
    output logic [NCH-1:0]   led_out
);

    localparam int DIV_W = $clog2(TICK_DIV);

    localparam logic [2:0] MODE_OFF     = 3'd0;
    localparam logic [2:0] MODE_ON      = 3'd1;
    localparam logic [2:0] MODE_BLINK   = 3'd2;
    localparam logic [2:0] MODE_ONESHOT = 3'd3;
    localparam logic [2:0] MODE_FOLLOW  = 3'd4;

    logic [DIV_W-1:0] presc;
    logic [2:0]       mode   [NCH];
    logic [CNT_W-1:0] period [NCH];
    logic [CNT_W-1:0] duty   [NCH];
    logic [CNT_W-1:0] phase  [NCH];
    logic [NCH-1:0]   armed;
    logic [NCH-1:0]   src_meta;
    logic [NCH-1:0]   src_sync;
    logic [NCH-1:0]   wr_sel;
    logic [NCH-1:0]   phase_wrap;
    logic [NCH-1:0]   armed_clr;
    logic [NCH-1:0]   led_next;

    // tick_o is registered so it is high exactly while presc sits at TICK_DIV-1
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            presc  <= '0;
            tick_o <= 1'b0;
        end else if (sync_clr || presc == DIV_W'(TICK_DIV - 1)) begin
            presc  <= '0;
            tick_o <= 1'b0;
        end else begin
            presc  <= presc + DIV_W'(1);
            tick_o <= (presc == DIV_W'(TICK_DIV - 2));
        end
    end

    always_comb begin
        wr_sel     = '0;
        phase_wrap = '0;
        armed_clr  = '0;
        led_next   = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_sel[i]     = cfg_we && (cfg_ch == CH_W'(i));
            phase_wrap[i] = (period[i] <= CNT_W'(1)) || (phase[i] >= period[i] - CNT_W'(1));
            armed_clr[i]  = (duty[i] == '0) || (tick_o && phase[i] == duty[i] - CNT_W'(1));
            case (mode[i])
                MODE_ON:      led_next[i] = 1'b1;
                MODE_BLINK:   led_next[i] = (period[i] != '0) && (phase[i] < duty[i]);
                MODE_ONESHOT: led_next[i] = armed[i] && (duty[i] != '0);
                MODE_FOLLOW:  led_next[i] = src_sync[i];
                default:      led_next[i] = 1'b0;
            endcase
        end
    end

    // A write owns its channel for that edge; otherwise sync_clr beats the tick advance
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                mode[i]   <= MODE_OFF;
                period[i] <= '0;
                duty[i]   <= '0;
                phase[i]  <= '0;
            end
            armed <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_sel[i]) begin
                    mode[i]   <= cfg_mode;
                    period[i] <= cfg_period;
                    duty[i]   <= cfg_duty;
                    phase[i]  <= '0;
                    armed[i]  <= (cfg_mode == MODE_ONESHOT);
                end else begin
                    if (sync_clr) begin
                        phase[i] <= '0;
                    end else if (tick_o) begin
                        phase[i] <= phase_wrap[i] ? '0 : phase[i] + CNT_W'(1);
                    end
                    if (armed_clr[i]) begin
                        armed[i] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            src_meta <= '0;
            src_sync <= '0;
            led_out  <= '0;
        end else begin
            src_meta <= src_in;
            src_sync <= src_meta;
            led_out  <= led_next;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: a per-cycle vector table for BLINK/config
// interaction, plus hand sequences for ONESHOT, FOLLOW and mid-pattern reset.
module tb_led_pattern_gen;

    localparam int NCH      = 5;
    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 16;
    localparam int CH_W     = 3;
    localparam int NVEC     = 29;

    localparam logic [2:0] M_OFF     = 3'd0;
    localparam logic [2:0] M_BLINK   = 3'd2;
    localparam logic [2:0] M_ONESHOT = 3'd3;
    localparam logic [2:0] M_FOLLOW  = 3'd4;

    logic             sys_clk   = 1'b0;
    logic             sys_rst_n = 1'b1;
    logic             cfg_we    = 1'b0;
    logic [CH_W-1:0]  cfg_ch    = '0;
    logic [2:0]       cfg_mode  = '0;
    logic [CNT_W-1:0] cfg_period = '0;
    logic [CNT_W-1:0] cfg_duty  = '0;
    logic             sync_clr  = 1'b0;
    logic [NCH-1:0]   src_in    = '0;
    logic             tick_o;
    logic [NCH-1:0]   led_out;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic             we;
        logic [CH_W-1:0]  ch;
        logic [2:0]       mode;
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] duty;
        logic             clr;
        logic [NCH-1:0]   led;
        logic             tick;
    } vec_t;

    vec_t vecs [NVEC];

    led_pattern_gen #(
        .NCH(NCH),
        .TICK_DIV(TICK_DIV),
        .CNT_W(CNT_W)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .cfg_we(cfg_we),
        .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode),
        .cfg_period(cfg_period),
        .cfg_duty(cfg_duty),
        .sync_clr(sync_clr),
        .src_in(src_in),
        .tick_o(tick_o),
        .led_out(led_out)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void set_vec(input int k, input logic we, input logic [CH_W-1:0] ch,
                                    input logic [2:0] mode, input int per, input int dty,
                                    input logic clr, input logic [NCH-1:0] led, input logic tick);
        vecs[k].we     = we;
        vecs[k].ch     = ch;
        vecs[k].mode   = mode;
        vecs[k].period = CNT_W'(per);
        vecs[k].duty   = CNT_W'(dty);
        vecs[k].clr    = clr;
        vecs[k].led    = led;
        vecs[k].tick   = tick;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic cycle();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic apply_stimulus(input logic we, input logic [CH_W-1:0] ch, input logic [2:0] mode,
                                  input logic [CNT_W-1:0] per, input logic [CNT_W-1:0] dty,
                                  input logic clr);
        cfg_we     = we;
        cfg_ch     = ch;
        cfg_mode   = mode;
        cfg_period = per;
        cfg_duty   = dty;
        sync_clr   = clr;
    endtask

    // Released at a negedge: tick should appear after edges 3, 7 with all LEDs dark
    task automatic check_after_release(input string tag);
        for (int n = 1; n <= 8; n++) begin
            cycle();
            check_output($sformatf("%s tick n%0d", tag, n), 32'(tick_o), 32'((n % 4) == 3));
            check_output($sformatf("%s led n%0d", tag, n), 32'(led_out), 32'(0));
        end
    endtask

    initial begin
        int ones;
        int first;
        int last;
        bit found;

        // k: per-cycle vectors relative to the first sync_clr write
        set_vec( 0, 1, 0, M_BLINK, 4, 2, 1, 5'b00000, 0);
        set_vec( 1, 1, 1, M_BLINK, 3, 5, 0, 5'b00001, 0);
        set_vec( 2, 0, 0, M_OFF,   0, 0, 0, 5'b00011, 0);
        set_vec( 3, 0, 0, M_OFF,   0, 0, 0, 5'b00011, 1);
        set_vec( 4, 0, 0, M_OFF,   0, 0, 0, 5'b00011, 0);
        set_vec( 5, 0, 0, M_OFF,   0, 0, 0, 5'b00011, 0);
        set_vec( 6, 1, 1, M_BLINK, 0, 5, 0, 5'b00011, 0);
        set_vec( 7, 0, 0, M_OFF,   0, 0, 0, 5'b00001, 1);
        set_vec( 8, 0, 0, M_OFF,   0, 0, 0, 5'b00001, 0);
        set_vec( 9, 0, 0, M_OFF,   0, 0, 0, 5'b00000, 0);
        set_vec(10, 1, 5, M_BLINK, 2, 1, 0, 5'b00000, 0);
        set_vec(11, 0, 0, M_OFF,   0, 0, 0, 5'b00000, 1);
        set_vec(12, 1, 1, M_BLINK, 4, 2, 1, 5'b00000, 0);
        for (int j = 1; j <= 16; j++) begin
            set_vec(12 + j, 0, 0, M_OFF, 0, 0, 0, (j <= 8) ? 5'b00011 : 5'b00000, (j % 4) == 3);
        end

        #2 sys_rst_n = 1'b0;
        #1;
        check_output("reset led", 32'(led_out), 32'(0));
        check_output("reset tick", 32'(tick_o), 32'(0));
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        check_after_release("release");

        for (int k = 0; k < NVEC; k++) begin
            apply_stimulus(vecs[k].we, vecs[k].ch, vecs[k].mode, vecs[k].period,
                           vecs[k].duty, vecs[k].clr);
            cycle();
            check_output($sformatf("vec%0d led", k), 32'(led_out), 32'(vecs[k].led));
            check_output($sformatf("vec%0d tick", k), 32'(tick_o), 32'(vecs[k].tick));
        end
        apply_stimulus(0, 0, M_OFF, 0, 0, 0);

        // ONESHOT duty=3 with sync_clr: high on edges 1..12 after the write
        apply_stimulus(1, 2, M_ONESHOT, 16'd8, 16'd3, 1);
        cycle();
        apply_stimulus(0, 0, M_OFF, 0, 0, 0);
        ones = 0;
        first = 0;
        last = 0;
        for (int m = 1; m <= 24; m++) begin
            cycle();
            if (led_out[2]) begin
                ones++;
                if (first == 0) first = m;
                last = m;
            end
        end
        check_output("oneshot high count", 32'(ones), 32'(12));
        check_output("oneshot first edge", 32'(first), 32'(1));
        check_output("oneshot last edge", 32'(last), 32'(12));

        apply_stimulus(1, 2, M_ONESHOT, 16'd8, 16'd0, 0);
        cycle();
        apply_stimulus(0, 0, M_OFF, 0, 0, 0);
        ones = 0;
        for (int m = 1; m <= 16; m++) begin
            cycle();
            if (led_out[2]) ones++;
        end
        check_output("oneshot duty0 high count", 32'(ones), 32'(0));

        apply_stimulus(1, 3, M_FOLLOW, 16'd0, 16'd0, 0);
        cycle();
        apply_stimulus(0, 0, M_OFF, 0, 0, 0);
        repeat (3) cycle();
        check_output("follow idle", 32'(led_out[3]), 32'(0));
        src_in[3] = 1'b1;
        cycle();
        check_output("follow rise e1", 32'(led_out[3]), 32'(0));
        cycle();
        check_output("follow rise e2", 32'(led_out[3]), 32'(0));
        cycle();
        check_output("follow rise e3", 32'(led_out[3]), 32'(1));
        src_in[3] = 1'b0;
        repeat (3) cycle();
        check_output("follow fall e3", 32'(led_out[3]), 32'(0));
        src_in[3] = 1'b1;
        cycle();
        src_in[3] = 1'b0;
        cycle();
        check_output("glitch e2", 32'(led_out[3]), 32'(0));
        cycle();
        check_output("glitch e3", 32'(led_out[3]), 32'(1));
        cycle();
        check_output("glitch e4", 32'(led_out[3]), 32'(0));

        src_in[3] = 1'b1;
        repeat (3) cycle();
        check_output("pre-reset follow", 32'(led_out[3]), 32'(1));
        found = 1'b0;
        for (int n = 0; n < 8 && !found; n++) begin
            if (tick_o) found = 1'b1;
            else cycle();
        end
        check_output("pre-reset tick seen", 32'(found), 32'(1));
        #2 sys_rst_n = 1'b0;
        #1;
        check_output("mid reset led", 32'(led_out), 32'(0));
        check_output("mid reset tick", 32'(tick_o), 32'(0));
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        check_after_release("rerelease");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
